// File: rtl/dec_char_streamer_pkg.sv
// Shared types and sizing for the decimal-character streamer.
// State encoding, character width and index-width helper live here.
package dec_char_streamer_pkg;

  localparam int unsigned NUM_CHARS_DEF = 34;
  localparam int unsigned CHAR_W        = 8;
  localparam int unsigned IDX_W_DEF     = $clog2(NUM_CHARS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND
  } state_t;

  // Index width for a word of n characters; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dec_char_streamer_lead_null_enc.sv
// Combinational priority encoder: index of the first non-null character of a word.
// Only characters 0..N-2 are examined; if all are null the result is N-1.
module lead_null_enc
  import dec_char_streamer_pkg::*;
#(
  parameter int unsigned NUM_CHARS = NUM_CHARS_DEF,
  parameter int unsigned IDX_W     = idx_w(NUM_CHARS)
) (
  input  logic [(NUM_CHARS-1)*CHAR_W-1:0] head_chars,
  output logic [IDX_W-1:0]                first_idx
);

  // Scan from the highest index down so the lowest non-null index wins.
  always_comb begin
    first_idx = IDX_W'(NUM_CHARS - 1);
    for (int i = NUM_CHARS - 2; i >= 0; i--) begin
      if (head_chars[(NUM_CHARS-2-i)*CHAR_W +: CHAR_W] != '0) begin
        first_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dec_char_streamer.sv
// Streams one ASCII result word from the binary-to-decimal stage as a valid/ready byte stream.
// Start to first tx_valid is 3 cycles when the source is ready; tx outputs hold while tx_ready is low.
module dec_char_streamer
  import dec_char_streamer_pkg::*;
#(
  parameter int unsigned NUM_CHARS = NUM_CHARS_DEF,
  parameter bit          SKIP_LEAD = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        start,
  input  logic [3:0]                  slot,
  output logic                        busy,
  output logic                        rden,
  output logic [3:0]                  rdaddrs,
  input  logic [NUM_CHARS*CHAR_W-1:0] rddata,
  input  logic [1:0]                  exceptCode,
  input  logic                        src_ready,
  output logic [CHAR_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        tx_last,
  output logic [1:0]                  tx_except,
  output logic                        done
);

  localparam int unsigned      IDX_W    = idx_w(NUM_CHARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  state_t                      state_q, state_d;
  logic [3:0]                  slot_q, slot_d;
  logic [NUM_CHARS*CHAR_W-1:0] word_q, word_d;
  logic [1:0]                  except_q, except_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        done_q, done_d;

  logic [IDX_W-1:0]            lead_idx;
  logic [CHAR_W-1:0]           cur_char;
  logic                        at_last;

  lead_null_enc #(
    .NUM_CHARS (NUM_CHARS),
    .IDX_W     (IDX_W)
  ) u_lead_null_enc (
    .head_chars (rddata[NUM_CHARS*CHAR_W-1:CHAR_W]),
    .first_idx  (lead_idx)
  );

  // Character 0 sits in the most significant byte of the word.
  always_comb begin
    cur_char = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_char = word_q[(NUM_CHARS-1-i)*CHAR_W +: CHAR_W];
      end
    end
  end

  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    word_d   = word_q;
    except_d = except_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          slot_d  = slot;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        // Source not ready yet: re-issue the read, indefinitely.
        if (src_ready) begin
          word_d   = rddata;
          except_d = exceptCode;
          idx_d    = SKIP_LEAD ? lead_idx : '0;
          state_d  = ST_SEND;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (at_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      word_q   <= '0;
      except_q <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      word_q   <= word_d;
      except_q <= except_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign rden      = (state_q == ST_READ);
  assign rdaddrs   = slot_q;
  assign tx_valid  = (state_q == ST_SEND);
  assign tx_data   = tx_valid ? cur_char : '0;
  assign tx_last   = tx_valid && at_last;
  assign tx_except = except_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dec_char_streamer.sv
// Scoreboard bench for dec_char_streamer: instance A skips leading nulls, instance B does not.
module tb_dec_char_streamer;

  localparam int NC = 34;

  typedef struct {
    logic [7:0] ch;
    logic       last;
    logic [1:0] exc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic [3:0]    slot = '0;
  logic [NC*8-1:0] rddata = '0;
  logic [1:0]    exceptCode = '0;
  logic          src_ready;
  logic          tx_ready = 1'b0;
  logic          dut_sel = 1'b0;

  logic          busy_a, rden_a, tx_valid_a, tx_last_a, done_a;
  logic [3:0]    rdaddrs_a;
  logic [7:0]    tx_data_a;
  logic [1:0]    tx_except_a;
  logic          busy_b, rden_b, tx_valid_b, tx_last_b, done_b;
  logic [3:0]    rdaddrs_b;
  logic [7:0]    tx_data_b;
  logic [1:0]    tx_except_b;

  logic          v_rden, v_tx_valid, v_tx_last, v_done;
  logic [3:0]    v_rdaddrs;
  logic [7:0]    v_tx_data;
  logic [1:0]    v_tx_except;

  int            n_asserts = 0;
  int            n_fail = 0;
  int            fail_req = 0;
  int            rd_seen = 0;
  exp_t          sb[$];

  always #5 CLK = ~CLK;

  dec_char_streamer #(.NUM_CHARS(NC), .SKIP_LEAD(1'b1)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .slot(slot),
    .busy(busy_a), .rden(rden_a), .rdaddrs(rdaddrs_a),
    .rddata(rddata), .exceptCode(exceptCode), .src_ready(src_ready),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
    .tx_last(tx_last_a), .tx_except(tx_except_a), .done(done_a)
  );

  dec_char_streamer #(.NUM_CHARS(NC), .SKIP_LEAD(1'b0)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .slot(slot),
    .busy(busy_b), .rden(rden_b), .rdaddrs(rdaddrs_b),
    .rddata(rddata), .exceptCode(exceptCode), .src_ready(src_ready),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
    .tx_last(tx_last_b), .tx_except(tx_except_b), .done(done_b)
  );

  assign v_rden      = dut_sel ? rden_b      : rden_a;
  assign v_rdaddrs   = dut_sel ? rdaddrs_b   : rdaddrs_a;
  assign v_tx_data   = dut_sel ? tx_data_b   : tx_data_a;
  assign v_tx_valid  = dut_sel ? tx_valid_b  : tx_valid_a;
  assign v_tx_last   = dut_sel ? tx_last_b   : tx_last_a;
  assign v_tx_except = dut_sel ? tx_except_b : tx_except_a;
  assign v_done      = dut_sel ? done_b      : done_a;

  // Upstream model: answers each read with a registered semaphore; the first fail_req reads are refused.
  always @(posedge CLK) begin
    if (RESET || start_a || start_b) begin
      rd_seen   <= 0;
      src_ready <= 1'b0;
    end else if (rden_a || rden_b) begin
      src_ready <= (rd_seen >= fail_req);
      rd_seen   <= rd_seen + 1;
    end else begin
      src_ready <= 1'b0;
    end
  end

  function automatic logic [NC*8-1:0] make_word(input string s);
    logic [NC*8-1:0] w;
    w = '0;
    for (int i = 0; i < s.len(); i++) w[(s.len()-1-i)*8 +: 8] = s[i];
    return w;
  endfunction

  function automatic logic [7:0] char_of(input logic [NC*8-1:0] w, input int k);
    return w[(NC-1-k)*8 +: 8];
  endfunction

  task automatic push_str(input string s, input logic [1:0] exc);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.ch = s[i]; e.last = (i == s.len() - 1); e.exc = exc;
      sb.push_back(e);
    end
  endtask

  task automatic push_all(input logic [NC*8-1:0] w, input logic [1:0] exc);
    exp_t e;
    for (int k = 0; k < NC; k++) begin
      e.ch = char_of(w, k); e.last = (k == NC - 1); e.exc = exc;
      sb.push_back(e);
    end
  endtask

  // Starts one stream on the selected instance and scores every handshake against the queue.
  task automatic run_and_score(input logic [3:0] exp_slot, input bit stall_mode,
                               output int first_valid, output int n_rden,
                               output int n_hs, output int n_done);
    exp_t       e;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic [1:0] prev_exc = '0;
    first_valid = -1; n_rden = 0; n_hs = 0; n_done = 0;
    if (dut_sel) start_b = 1'b1; else start_a = 1'b1;
    for (int cyc = 1; cyc <= 300 && n_done == 0; cyc++) begin
      @(posedge CLK); #1;
      if (cyc == 1) begin start_a = 1'b0; start_b = 1'b0; end
      tx_ready = stall_mode ? ((cyc % 4) == 1 || (cyc % 4) == 0) : 1'b1;
      @(negedge CLK);
      if (v_rden) begin
        n_rden++;
        n_asserts++;
        if (v_rdaddrs !== exp_slot) begin
          n_fail++;
          $display("FAIL rdaddrs: got %0d expected %0d", v_rdaddrs, exp_slot);
        end
      end
      if (prev_stall) begin
        n_asserts++;
        if ({v_tx_data, v_tx_last, v_tx_except} !== {prev_data, prev_last, prev_exc}) begin
          n_fail++;
          $display("FAIL stall_hold: got data=%02h last=%0b exc=%0d expected data=%02h last=%0b exc=%0d",
                   v_tx_data, v_tx_last, v_tx_except, prev_data, prev_last, prev_exc);
        end
      end
      if (v_tx_valid && first_valid < 0) first_valid = cyc;
      if (v_tx_valid && tx_ready) begin
        n_hs++;
        n_asserts++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_char: got %02h expected no character", v_tx_data);
        end else begin
          e = sb.pop_front();
          if ({v_tx_data, v_tx_last, v_tx_except} !== {e.ch, e.last, e.exc}) begin
            n_fail++;
            $display("FAIL char: got data=%02h last=%0b exc=%0d expected data=%02h last=%0b exc=%0d",
                     v_tx_data, v_tx_last, v_tx_except, e.ch, e.last, e.exc);
          end
        end
      end
      prev_stall = v_tx_valid && !tx_ready;
      prev_data  = v_tx_data;
      prev_last  = v_tx_last;
      prev_exc   = v_tx_except;
      if (v_done) n_done++;
    end
    n_asserts++;
    if (n_done == 0) begin
      n_fail++;
      $display("FAIL done_timeout: got no done pulse expected one within 300 cycles");
    end
    n_asserts++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_chars: got %0d characters unsent expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_asserts++;
    if ({busy_a, rden_a, tx_valid_a, tx_last_a, done_a, rdaddrs_a, tx_data_a, tx_except_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got busy=%0b rden=%0b valid=%0b last=%0b done=%0b addr=%0d data=%02h exc=%0d expected all 0",
               busy_a, rden_a, tx_valid_a, tx_last_a, done_a, rdaddrs_a, tx_data_a, tx_except_a);
    end
    n_asserts++;
    if ({busy_b, rden_b, tx_valid_b, tx_last_b, done_b, rdaddrs_b, tx_data_b, tx_except_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got busy=%0b rden=%0b valid=%0b last=%0b done=%0b addr=%0d data=%02h exc=%0d expected all 0",
               busy_b, rden_b, tx_valid_b, tx_last_b, done_b, rdaddrs_b, tx_data_b, tx_except_b);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    n_asserts++;
    if ({busy_a, busy_b, rden_a, rden_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy/rden=%b expected 0000", {busy_a, busy_b, rden_a, rden_b});
    end
  endtask

  task automatic test_basic;
    int fv, nr, nh, nd;
    dut_sel = 1'b0; slot = 4'd3; fail_req = 0;
    rddata = make_word("-1.5E+0"); exceptCode = 2'b01;
    push_str("-1.5E+0", 2'b01);
    run_and_score(4'd3, 1'b0, fv, nr, nh, nd);
    n_asserts++;
    if (fv !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", fv); end
    n_asserts++;
    if (nr !== 1) begin n_fail++; $display("FAIL basic_reads: got %0d expected 1", nr); end
    n_asserts++;
    if (nh !== 7) begin n_fail++; $display("FAIL basic_count: got %0d expected 7", nh); end
  endtask

  task automatic test_retry;
    int fv, nr, nh, nd;
    dut_sel = 1'b0; slot = 4'd3; fail_req = 2;
    rddata = make_word("42"); exceptCode = 2'b00;
    push_str("42", 2'b00);
    run_and_score(4'd3, 1'b0, fv, nr, nh, nd);
    fail_req = 0;
    n_asserts++;
    if (nr !== 3) begin n_fail++; $display("FAIL retry_reads: got %0d expected 3", nr); end
    n_asserts++;
    if (fv !== 7) begin n_fail++; $display("FAIL retry_latency: got %0d expected 7", fv); end
  endtask

  task automatic test_stall;
    int fv, nr, nh, nd;
    dut_sel = 1'b0; slot = 4'd9; fail_req = 0;
    rddata = make_word("123.75E-3"); exceptCode = 2'b10;
    push_str("123.75E-3", 2'b10);
    run_and_score(4'd9, 1'b1, fv, nr, nh, nd);
    n_asserts++;
    if (nh !== 9) begin n_fail++; $display("FAIL stall_count: got %0d expected 9", nh); end
  endtask

  task automatic test_all_null;
    int   fv, nr, nh, nd;
    exp_t e;
    dut_sel = 1'b0; slot = 4'd0; fail_req = 0;
    rddata = '0; exceptCode = 2'b01;
    e.ch = 8'h00; e.last = 1'b1; e.exc = 2'b01;
    sb.push_back(e);
    run_and_score(4'd0, 1'b0, fv, nr, nh, nd);
    n_asserts++;
    if (nh !== 1) begin n_fail++; $display("FAIL null_count: got %0d expected 1", nh); end
  endtask

  task automatic test_back_to_back;
    int fv, nr, nh, nd;
    dut_sel = 1'b0; slot = 4'd5; fail_req = 0;
    rddata = make_word("7"); exceptCode = 2'b00;
    push_str("7", 2'b00);
    run_and_score(4'd5, 1'b0, fv, nr, nh, nd);
    // The next start is raised in the cycle the first stream's done is high.
    slot = 4'd6;
    rddata = make_word("-8"); exceptCode = 2'b01;
    push_str("-8", 2'b01);
    run_and_score(4'd6, 1'b0, fv, nr, nh, nd);
    n_asserts++;
    if (fv !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 3", fv); end
    n_asserts++;
    if (nh !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", nh); end
  endtask

  task automatic test_no_skip;
    int fv, nr, nh, nd;
    logic [NC*8-1:0] w;
    dut_sel = 1'b1; slot = 4'd2; fail_req = 0;
    w = make_word("9.99E+9");
    rddata = w; exceptCode = 2'b11;
    push_all(w, 2'b11);
    run_and_score(4'd2, 1'b0, fv, nr, nh, nd);
    n_asserts++;
    if (nh !== 34) begin n_fail++; $display("FAIL noskip_count: got %0d expected 34", nh); end
  endtask

  task automatic test_reset_mid;
    int fv, nr, nh, nd;
    int hs = 0;
    int bad = 0;
    bit hit = 1'b0;
    logic [NC*8-1:0] w;
    dut_sel = 1'b1; slot = 4'd4; fail_req = 0; tx_ready = 1'b1;
    for (int k = 0; k < NC; k++) w[(NC-1-k)*8 +: 8] = 8'h41 + 8'(k);
    rddata = w; exceptCode = 2'b10;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 100 && !hit; cyc++) begin
      @(posedge CLK); #1;
      if (cyc == 1) start_b = 1'b0;
      @(negedge CLK);
      if (tx_valid_b) begin
        if (hs == 5) begin
          hit = 1'b1;
          n_asserts++;
          if (tx_data_b !== char_of(w, 5)) begin
            n_fail++;
            $display("FAIL mid_char5: got %02h expected %02h", tx_data_b, char_of(w, 5));
          end
        end
        hs++;
      end
    end
    if (!hit) begin
      n_asserts++; n_fail++;
      $display("FAIL mid_timeout: got %0d characters expected index 5 within 100 cycles", hs);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    n_asserts++;
    if ({tx_valid_b, busy_b, done_b} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset: got valid/busy/done=%b expected 000", {tx_valid_b, busy_b, done_b});
    end
    repeat (8) begin
      @(negedge CLK);
      if (done_b || tx_valid_b) bad++;
    end
    n_asserts++;
    if (bad != 0) begin n_fail++; $display("FAIL mid_quiet: got %0d active cycles expected 0", bad); end
    w = make_word("-0.5");
    rddata = w; exceptCode = 2'b00; slot = 4'd8;
    push_all(w, 2'b00);
    run_and_score(4'd8, 1'b0, fv, nr, nh, nd);
    n_asserts++;
    if (fv !== 3) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 3", fv); end
    n_asserts++;
    if (nh !== 34) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 34", nh); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_retry;
    test_stall;
    test_all_null;
    test_back_to_back;
    test_no_skip;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_char_streamer.md
DEC_CHAR_STREAMER -- requirements
Module: dec_char_streamer

Interface
REQ-001 Parameter NUM_CHARS, default 34: ASCII characters per result word; 8 bits each, so 272 bits.
REQ-002 Parameter SKIP_LEAD, default 1: 1 suppresses leading 8'h00 characters.
REQ-003 CLK  in  1  sole clock; all logic on the rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request to stream one result slot.
REQ-006 slot  in  4  result-RAM address to stream; sampled with start.
REQ-007 busy  out  1  high from the cycle after start is accepted until done.
REQ-008 rden  out  1  read strobe to the binary-to-decimal-character stage.
REQ-009 rdaddrs  out  4  read address to that stage.
REQ-010 rddata  in  272  ASCII result word; character 0 is rddata[271:264].
REQ-011 exceptCode  in  2  exception code accompanying rddata.
REQ-012 src_ready  in  1  registered semaphore from the upstream stage; 1 = slot result is valid.
REQ-013 tx_data  out  8  current output character.
REQ-014 tx_valid  out  1  tx_data valid.
REQ-015 tx_ready  in  1  sink accepts on tx_valid & tx_ready.
REQ-016 tx_last  out  1  high with the final character (index NUM_CHARS-1).
REQ-017 tx_except  out  2  captured exceptCode; valid while tx_valid.
REQ-018 done  out  1  one-cycle pulse after the last handshake.

Function
REQ-019 FSM states: IDLE, READ, WAIT, SEND.
- IDLE: start=1 latches slot and goes to READ.
- start is ignored when not in IDLE.
REQ-020 READ: drive rden=1 and rdaddrs=latched slot for exactly one cycle, then go to WAIT.
REQ-021 WAIT: sample src_ready and rddata in the cycle after READ.
- src_ready=0: return to READ (retry, unbounded); rdaddrs holds slot.
- src_ready=1: capture rddata and exceptCode into local registers, then go to SEND.
REQ-022 On capture with SKIP_LEAD=1, the start index is the first character not equal to 8'h00.
- If characters 0..NUM_CHARS-2 are all 8'h00, the start index is NUM_CHARS-1.
- With SKIP_LEAD=0, the start index is 0.
REQ-023 SEND: tx_valid=1 and tx_data=char[index].
- On each handshake, index increments.
- tx_data, tx_last and tx_except hold stable while tx_valid & ~tx_ready.
REQ-024 Handshake with tx_last=1: next state IDLE, done=1 for that following cycle, tx_valid=0.
REQ-025 Latency, start to first tx_valid with src_ready=1 on the first try: 3 cycles (READ, WAIT, SEND).
REQ-026 rden is never asserted outside READ; at most one read is outstanding.
REQ-027 A new start in the cycle done is high is accepted (IDLE has been re-entered).

Reset
REQ-028 RESET=1 forces IDLE; busy, rden, tx_valid, tx_last and done = 0; rdaddrs, tx_data, tx_except and index = 0; this holds in any state.
REQ-029 Reset mid-stream abandons the word; no further characters are emitted and done is not pulsed.

Structure
REQ-030 The shared package holds:
- the state enum;
- the NUM_CHARS default;
- the char width (8);
- the index width, $clog2(NUM_CHARS).
REQ-031 One sub-module, lead_null_enc: combinational priority encoder returning the index of the first non-8'h00 character; the FSM lives in the top module.

Verification
REQ-032 Slot 3, rddata = "-1.5E+0" right-aligned and null-padded, src_ready=1, tx_ready=1:
- tx_data sequence is '-','1','.','5','E','+','0' on consecutive cycles;
- tx_last on '0', then done.
REQ-033 src_ready=0 for two WAIT samples, then 1:
- rden pulses three times at address 3;
- the first tx_valid comes 7 cycles after start.
REQ-034 tx_ready toggling 1,0,0,1: tx_data holds its value over the stalled cycles and no character is duplicated or dropped.
REQ-035 All-null rddata with SKIP_LEAD=1: exactly one character, 8'h00, with tx_last=1.
REQ-036 SKIP_LEAD=0: exactly 34 characters are emitted; tx_except=2'b11 is held throughout for exceptCode=2'b11.
REQ-037 RESET during SEND at index 5: the next cycle has tx_valid=0 and busy=0; there is no done pulse; a following start streams normally.
